// File: rtl/tracker_pkg.sv
// rtl/tracker_pkg.sv - shared defaults, widths and FSM state type for the centroid tracker
package tracker_pkg;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int SUM_W_DEF = 28;
  localparam int CNT_W_DEF = 19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_X   = 2'd1,
    DIV_Y   = 2'd2,
    PUBLISH = 2'd3
  } state_e;
endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, SUM_W iterations, first iteration on the start edge
module seq_divider
  import tracker_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);
  localparam int IW = $clog2(SUM_W) + 1;

  logic [CNT_W-1:0] rem_q, rem_d, rem_in;
  logic [SUM_W-1:0] quo_q, quo_d, quo_in;
  logic [IW-1:0]    iter_q, iter_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W:0]   trial, rem_step;
  logic             ge;

  // One shift/subtract step, fed from the operands directly when starting.
  always_comb begin
    rem_in   = busy_q ? rem_q : '0;
    quo_in   = busy_q ? quo_q : dividend;
    trial    = {rem_in, quo_in[SUM_W-1]};
    ge       = trial >= {1'b0, divisor};
    rem_step = ge ? (trial - {1'b0, divisor}) : trial;

    rem_d  = rem_q;
    quo_d  = quo_q;
    iter_d = iter_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start && !busy_q) begin
      rem_d  = rem_step[CNT_W-1:0];
      quo_d  = {quo_in[SUM_W-2:0], ge};
      iter_d = IW'(SUM_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_step[CNT_W-1:0];
      quo_d  = {quo_in[SUM_W-2:0], ge};
      iter_d = iter_q - 1'b1;
      if (iter_q == IW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;
endmodule

// File: rtl/target_centroid_tracker.sv
// rtl/target_centroid_tracker.sv - per-frame target centroid, validity and dx tracker
// Optional bounding box outputs built when TRACKER_BBOX_EN is defined.
module target_centroid_tracker
  import tracker_pkg::*;
#(
  parameter int H_ACT      = H_ACT_DEF,
  parameter int V_ACT      = V_ACT_DEF,
  parameter int MIN_PIXELS = 16,
  parameter int SUM_W      = SUM_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        DE,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        is_target_color,
  output logic [9:0]  centroid_x,
  output logic [9:0]  centroid_y,
  output logic        obj_valid,
  output logic [10:0] dx,
  output logic [9:0]  bbox_xmin,
  output logic [9:0]  bbox_xmax,
  output logic [9:0]  bbox_ymin,
  output logic [9:0]  bbox_ymax,
  output logic        result_valid,
  output logic        frame_drop
);
  function automatic logic [9:0] clamp_q(input logic [SUM_W-1:0] q, input logic [9:0] lim);
    return (q > SUM_W'(lim)) ? lim : q[9:0];
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, acc_cnt, snap_cnt_q, snap_cnt_d;
  logic [SUM_W-1:0] sx_q, sx_d, acc_sx, snap_sx_q, snap_sx_d;
  logic [SUM_W-1:0] sy_q, sy_d, acc_sy, snap_sy_q, snap_sy_d;
  logic             pend_q, pend_d;
  logic [9:0]       qx_q, qx_d, qy_q, qy_d;
  logic [9:0]       cx_q, cx_d, cy_q, cy_d;
  logic             ov_q, ov_d, rv_q, rv_d, fd_q, fd_d;
  logic [10:0]      dx_q, dx_d;
  logic             hit, close, accept, snap_ok;
  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_dividend, div_quotient;

  always_comb begin
    hit     = pix_en && DE && is_target_color;
    close   = pix_en && DE && (x_pixel == 10'(H_ACT - 1)) && (y_pixel == 10'(V_ACT - 1));
    accept  = close && (state_q == IDLE) && !pend_q;
    snap_ok = snap_cnt_q >= CNT_W'(MIN_PIXELS);

    // The closing pixel is counted, then the running sums restart for the next frame.
    acc_cnt = cnt_q + CNT_W'(hit);
    acc_sx  = sx_q + (hit ? SUM_W'(x_pixel) : '0);
    acc_sy  = sy_q + (hit ? SUM_W'(y_pixel) : '0);
    cnt_d   = close ? '0 : acc_cnt;
    sx_d    = close ? '0 : acc_sx;
    sy_d    = close ? '0 : acc_sy;

    snap_cnt_d = accept ? acc_cnt : snap_cnt_q;
    snap_sx_d  = accept ? acc_sx : snap_sx_q;
    snap_sy_d  = accept ? acc_sy : snap_sy_q;
    pend_d     = accept ? 1'b1 : pend_q;
    fd_d       = close && !accept;

    div_start    = 1'b0;
    div_dividend = (state_q == DIV_X) ? snap_sy_q : snap_sx_q;
    state_d = state_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    dx_d    = dx_q;
    rv_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (snap_ok) begin
            div_start = 1'b1;
            state_d   = DIV_X;
          end else begin
            state_d = PUBLISH;
          end
        end
      end
      DIV_X: begin
        if (div_done) begin
          qx_d      = clamp_q(div_quotient, 10'(H_ACT - 1));
          div_start = 1'b1;
          state_d   = DIV_Y;
        end
      end
      DIV_Y: begin
        if (div_done) begin
          qy_d    = clamp_q(div_quotient, 10'(V_ACT - 1));
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        rv_d    = 1'b1;
        state_d = IDLE;
        if (snap_ok) begin
          cx_d = qx_q;
          cy_d = qy_q;
          ov_d = 1'b1;
          dx_d = ov_q ? ({1'b0, qx_q} - {1'b0, cx_q}) : 11'd0;
        end else begin
          ov_d = 1'b0;
          dx_d = 11'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      snap_cnt_q <= '0;
      snap_sx_q  <= '0;
      snap_sy_q  <= '0;
      pend_q     <= 1'b0;
      qx_q       <= '0;
      qy_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      ov_q       <= 1'b0;
      dx_q       <= '0;
      rv_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      snap_cnt_q <= snap_cnt_d;
      snap_sx_q  <= snap_sx_d;
      snap_sy_q  <= snap_sy_d;
      pend_q     <= pend_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      ov_q       <= ov_d;
      dx_q       <= dx_d;
      rv_q       <= rv_d;
      fd_q       <= fd_d;
    end
  end

  seq_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .resetn   (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (snap_cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

`ifdef TRACKER_BBOX_EN
  logic [9:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [9:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [9:0] s_xmin_q, s_xmin_d, s_xmax_q, s_xmax_d, s_ymin_q, s_ymin_d, s_ymax_q, s_ymax_d;
  logic [9:0] b_xmin_q, b_xmin_d, b_xmax_q, b_xmax_d, b_ymin_q, b_ymin_d, b_ymax_q, b_ymax_d;
  logic       bbox_pub;

  always_comb begin
    acc_xmin = (hit && x_pixel < xmin_q) ? x_pixel : xmin_q;
    acc_xmax = (hit && x_pixel > xmax_q) ? x_pixel : xmax_q;
    acc_ymin = (hit && y_pixel < ymin_q) ? y_pixel : ymin_q;
    acc_ymax = (hit && y_pixel > ymax_q) ? y_pixel : ymax_q;
    xmin_d   = close ? 10'd1023 : acc_xmin;
    xmax_d   = close ? 10'd0 : acc_xmax;
    ymin_d   = close ? 10'd1023 : acc_ymin;
    ymax_d   = close ? 10'd0 : acc_ymax;
    s_xmin_d = accept ? acc_xmin : s_xmin_q;
    s_xmax_d = accept ? acc_xmax : s_xmax_q;
    s_ymin_d = accept ? acc_ymin : s_ymin_q;
    s_ymax_d = accept ? acc_ymax : s_ymax_q;
    bbox_pub = (state_q == PUBLISH) && snap_ok;
    b_xmin_d = bbox_pub ? s_xmin_q : b_xmin_q;
    b_xmax_d = bbox_pub ? s_xmax_q : b_xmax_q;
    b_ymin_d = bbox_pub ? s_ymin_q : b_ymin_q;
    b_ymax_d = bbox_pub ? s_ymax_q : b_ymax_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      xmin_q <= 10'd1023; xmax_q <= '0; ymin_q <= 10'd1023; ymax_q <= '0;
      s_xmin_q <= '0; s_xmax_q <= '0; s_ymin_q <= '0; s_ymax_q <= '0;
      b_xmin_q <= '0; b_xmax_q <= '0; b_ymin_q <= '0; b_ymax_q <= '0;
    end else begin
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
      s_xmin_q <= s_xmin_d; s_xmax_q <= s_xmax_d; s_ymin_q <= s_ymin_d; s_ymax_q <= s_ymax_d;
      b_xmin_q <= b_xmin_d; b_xmax_q <= b_xmax_d; b_ymin_q <= b_ymin_d; b_ymax_q <= b_ymax_d;
    end
  end

  assign bbox_xmin = b_xmin_q;
  assign bbox_xmax = b_xmax_q;
  assign bbox_ymin = b_ymin_q;
  assign bbox_ymax = b_ymax_q;
`else
  assign bbox_xmin = '0;
  assign bbox_xmax = '0;
  assign bbox_ymin = '0;
  assign bbox_ymax = '0;
`endif

  assign centroid_x   = cx_q;
  assign centroid_y   = cy_q;
  assign obj_valid    = ov_q;
  assign dx           = dx_q;
  assign result_valid = rv_q;
  assign frame_drop   = fd_q;
endmodule

// File: tb/tb_target_centroid_tracker.sv
// tb/tb_target_centroid_tracker.sv - directed self-checking bench for target_centroid_tracker
module tb_target_centroid_tracker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b0;
  logic        DE = 1'b0;
  logic [9:0]  x_pixel = '0;
  logic [9:0]  y_pixel = '0;
  logic        is_target_color = 1'b0;
  logic [9:0]  centroid_x, centroid_y;
  logic        obj_valid;
  logic [10:0] dx;
  logic [9:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic        result_valid, frame_drop;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef TRACKER_BBOX_EN
  localparam bit BBOX = 1'b1;
`else
  localparam bit BBOX = 1'b0;
`endif

  always #5 clk = ~clk;

  target_centroid_tracker dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .is_target_color(is_target_color),
    .centroid_x(centroid_x), .centroid_y(centroid_y), .obj_valid(obj_valid), .dx(dx),
    .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax),
    .result_valid(result_valid), .frame_drop(frame_drop)
  );

  task automatic drive_pix(input int x, input int y, input bit t);
    @(negedge clk);
    pix_en = 1'b1; DE = 1'b1; x_pixel = 10'(x); y_pixel = 10'(y); is_target_color = t;
  endtask

  task automatic quiet();
    pix_en = 1'b0; DE = 1'b0; is_target_color = 1'b0;
  endtask

  task automatic send_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        drive_pix(x, y, 1'b1);
  endtask

  // k counts negedges after the closing edge; k=0 shows the state right after it.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      quiet();
      if (result_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (centroid_x !== 10'd0) begin n_bad++; $display("FAIL reset_cx: got %0d want 0", centroid_x); end
    n_cmp++; if (centroid_y !== 10'd0) begin n_bad++; $display("FAIL reset_cy: got %0d want 0", centroid_y); end
    n_cmp++; if (obj_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", obj_valid); end
    n_cmp++; if (dx !== 11'd0) begin n_bad++; $display("FAIL reset_dx: got %0d want 0", dx); end
    n_cmp++; if (result_valid !== 1'b0 || frame_drop !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got rv=%0b fd=%0b want 0/0", result_valid, frame_drop); end
    n_cmp++; if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} !== 40'd0) begin n_bad++; $display("FAIL reset_bbox: got %0d/%0d/%0d/%0d want 0", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_min_pixels();
    int lat;
    drive_pix(100, 50, 1'b1);
    drive_pix(639, 479, 1'b0);
    wait_result(lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL small_latency: got %0d want 2", lat); end
    n_cmp++; if (obj_valid !== 1'b0 || dx !== 11'd0) begin n_bad++; $display("FAIL small_valid_dx: got %0b/%0d want 0/0", obj_valid, dx); end
    n_cmp++; if (centroid_x !== 10'd0 || centroid_y !== 10'd0) begin n_bad++; $display("FAIL small_hold: got %0d,%0d want 0,0", centroid_x, centroid_y); end
  endtask

  task automatic test_square();
    int lat;
    send_rect(200, 209, 100, 109);
    drive_pix(639, 479, 1'b0);
    wait_result(lat);
    n_cmp++; if (lat !== 58) begin n_bad++; $display("FAIL sq_latency: got %0d want 58", lat); end
    n_cmp++; if (centroid_x !== 10'd204 || centroid_y !== 10'd104) begin n_bad++; $display("FAIL sq_centroid: got %0d,%0d want 204,104", centroid_x, centroid_y); end
    n_cmp++; if (obj_valid !== 1'b1 || dx !== 11'd0) begin n_bad++; $display("FAIL sq_valid_dx: got %0b/%0d want 1/0", obj_valid, dx); end
    n_cmp++; if (bbox_xmin !== (BBOX ? 10'd200 : 10'd0) || bbox_xmax !== (BBOX ? 10'd209 : 10'd0) ||
                 bbox_ymin !== (BBOX ? 10'd100 : 10'd0) || bbox_ymax !== (BBOX ? 10'd109 : 10'd0)) begin
      n_bad++; $display("FAIL sq_bbox: got %0d/%0d/%0d/%0d", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
    end
    @(negedge clk);
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL sq_pulse_width: got %0b want 0", result_valid); end
  endtask

  task automatic test_motion();
    int lat;
    send_rect(220, 229, 100, 109);
    drive_pix(639, 479, 1'b0);
    wait_result(lat);
    n_cmp++; if (centroid_x !== 10'd224 || dx !== 11'd20) begin n_bad++; $display("FAIL right_move: got cx=%0d dx=%0d want 224/20", centroid_x, $signed(dx)); end
    send_rect(190, 199, 100, 109);
    drive_pix(639, 479, 1'b0);
    wait_result(lat);
    n_cmp++; if (centroid_x !== 10'd194 || dx !== 11'h7E2) begin n_bad++; $display("FAIL left_move: got cx=%0d dx=%0d want 194/-30", centroid_x, $signed(dx)); end
  endtask

  task automatic test_last_row();
    int lat;
    send_rect(0, 638, 479, 479);
    drive_pix(639, 479, 1'b1);
    wait_result(lat);
    n_cmp++; if (lat !== 58) begin n_bad++; $display("FAIL row_latency: got %0d want 58", lat); end
    n_cmp++; if (centroid_x !== 10'd319 || centroid_y !== 10'd479) begin n_bad++; $display("FAIL row_centroid: got %0d,%0d want 319,479", centroid_x, centroid_y); end
    n_cmp++; if (obj_valid !== 1'b1 || dx !== 11'd125) begin n_bad++; $display("FAIL row_valid_dx: got %0b/%0d want 1/125", obj_valid, $signed(dx)); end
    n_cmp++; if (bbox_xmin !== 10'd0 || bbox_xmax !== (BBOX ? 10'd639 : 10'd0) ||
                 bbox_ymin !== (BBOX ? 10'd479 : 10'd0) || bbox_ymax !== (BBOX ? 10'd479 : 10'd0)) begin
      n_bad++; $display("FAIL row_bbox: got %0d/%0d/%0d/%0d", bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax);
    end
  endtask

  task automatic test_overrun();
    int lat = -1;
    int drops = 0;
    send_rect(200, 209, 100, 109);
    drive_pix(639, 479, 1'b0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      quiet();
      if (frame_drop) drops++;
      if (result_valid) begin
        lat = k;
        break;
      end
      if (k == 5) begin
        pix_en = 1'b1; DE = 1'b1; x_pixel = 10'd5; y_pixel = 10'd5; is_target_color = 1'b1;
      end
      if (k == 10) begin
        pix_en = 1'b1; DE = 1'b1; x_pixel = 10'd639; y_pixel = 10'd479; is_target_color = 1'b0;
      end
    end
    n_cmp++; if (drops !== 1) begin n_bad++; $display("FAIL ovr_drop_count: got %0d want 1", drops); end
    n_cmp++; if (lat !== 58) begin n_bad++; $display("FAIL ovr_latency: got %0d want 58", lat); end
    n_cmp++; if (centroid_x !== 10'd204 || centroid_y !== 10'd104 || dx !== 11'h78D) begin
      n_bad++; $display("FAIL ovr_result: got %0d,%0d dx=%0d want 204,104 dx=-115", centroid_x, centroid_y, $signed(dx));
    end
    send_rect(220, 229, 100, 109);
    drive_pix(639, 479, 1'b0);
    wait_result(lat);
    n_cmp++; if (centroid_x !== 10'd224 || dx !== 11'd20) begin n_bad++; $display("FAIL ovr_next_frame: got cx=%0d dx=%0d want 224/20", centroid_x, $signed(dx)); end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    int seen = 0;
    send_rect(200, 209, 100, 109);
    drive_pix(639, 479, 1'b0);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      quiet();
      if (result_valid) seen++;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_cmp++; if (centroid_x !== 10'd0 || centroid_y !== 10'd0 || obj_valid !== 1'b0 || dx !== 11'd0) begin
      n_bad++; $display("FAIL rst_outputs: got %0d,%0d v=%0b dx=%0d want 0", centroid_x, centroid_y, obj_valid, dx);
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_no_result: got %0d pulses want 0", seen); end
    send_rect(200, 209, 100, 109);
    drive_pix(639, 479, 1'b0);
    wait_result(lat);
    n_cmp++; if (lat !== 58 || centroid_x !== 10'd204 || centroid_y !== 10'd104 || dx !== 11'd0 || obj_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_recover: got lat=%0d %0d,%0d dx=%0d v=%0b want 58 204,104 0 1", lat, centroid_x, centroid_y, $signed(dx), obj_valid);
    end
  endtask

  initial begin
    test_reset();
    test_min_pixels();
    test_square();
    test_motion();
    test_last_row();
    test_overrun();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
